// File: rtl/mux4_bus_arbiter_pkg.sv
// rtl/mux4_bus_arbiter_pkg.sv - shared state encodings and defaults for the 4:1 bus arbiter
package mux4_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_TURN = 2'd2
   } state_t;

   localparam int unsigned DEF_TURNAROUND = 1;
   localparam int unsigned DEF_MAX_HOLD   = 16;

   function automatic logic [3:0] onehot4(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/mux4_bus_arbiter_rr_pick4.sv
// rtl/mux4_bus_arbiter_rr_pick4.sv - combinational round-robin picker over four requests
module rr_pick4 (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [1:0] winner,
   output logic       any_req
);

   logic [1:0] idx;
   logic       found;

   // Search ptr+1, ptr+2, ptr+3 and finally ptr itself; the 2-bit add wraps mod 4.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 1; k <= 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
      any_req = |req;
   end

endmodule

// File: rtl/mux4_bus_arbiter.sv
// rtl/mux4_bus_arbiter.sv - round-robin owner/turnaround sequencer for the shared tri-state bus
module mux4_bus_arbiter
   import mux4_bus_arbiter_pkg::*;
#(
   parameter int unsigned TURNAROUND = DEF_TURNAROUND,
   parameter int unsigned MAX_HOLD   = DEF_MAX_HOLD
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       bus_en,
   output logic       busy
);

   localparam logic [3:0] TURN_INIT = 4'(TURNAROUND);
   localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);

   state_t     state_q, state_d;
   logic [3:0] gnt_q, gnt_d;
   logic [1:0] sel_q, sel_d;
   logic       bus_en_q, bus_en_d;
   logic       busy_q, busy_d;
   logic [1:0] ptr_q, ptr_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic [3:0] turn_cnt_q, turn_cnt_d;

   logic [1:0] winner;
   logic       any_req;
   logic       grant_now;
   logic       hold_expired;

   rr_pick4 u_pick (
      .req     (req),
      .ptr     (ptr_q),
      .winner  (winner),
      .any_req (any_req)
   );

   assign hold_expired = (HOLD_MAX != 8'd0) && (hold_cnt_q == HOLD_MAX);

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      sel_d      = sel_q;
      bus_en_d   = bus_en_q;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;
      turn_cnt_d = turn_cnt_q;
      grant_now  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            grant_now = any_req;
         end
         ST_OWN: begin
            // Release wins over any competing request; sel keeps the old owner during TURN.
            if (!req[sel_q] || hold_expired) begin
               state_d    = ST_TURN;
               gnt_d      = 4'b0000;
               bus_en_d   = 1'b0;
               hold_cnt_d = 8'd0;
               turn_cnt_d = TURN_INIT;
            end else if (hold_cnt_q != 8'hFF) begin
               hold_cnt_d = hold_cnt_q + 8'd1;
            end
         end
         ST_TURN: begin
            if (turn_cnt_q <= 4'd1) begin
               turn_cnt_d = 4'd0;
               if (any_req) begin
                  grant_now = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               turn_cnt_d = turn_cnt_q - 4'd1;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            gnt_d      = 4'b0000;
            bus_en_d   = 1'b0;
            hold_cnt_d = 8'd0;
            turn_cnt_d = 4'd0;
         end
      endcase

      if (grant_now) begin
         state_d    = ST_OWN;
         gnt_d      = onehot4(winner);
         sel_d      = winner;
         bus_en_d   = 1'b1;
         ptr_d      = winner;
         hold_cnt_d = 8'd1;
         turn_cnt_d = 4'd0;
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         gnt_q      <= 4'b0000;
         sel_q      <= 2'b00;
         bus_en_q   <= 1'b0;
         busy_q     <= 1'b0;
         ptr_q      <= 2'd3;
         hold_cnt_q <= 8'd0;
         turn_cnt_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         sel_q      <= sel_d;
         bus_en_q   <= bus_en_d;
         busy_q     <= busy_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
         turn_cnt_q <= turn_cnt_d;
      end
   end

   assign gnt    = gnt_q;
   assign sel    = sel_q;
   assign bus_en = bus_en_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_mux4_bus_arbiter.sv
// tb/tb_mux4_bus_arbiter.sv - randomized and directed self-check of mux4_bus_arbiter against a reference model
module tb_mux4_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req_a = 4'b0000;
   logic [3:0] req_b = 4'b0000;
   logic [3:0] gnt_a, gnt_b;
   logic [1:0] sel_a, sel_b;
   logic       bus_en_a, bus_en_b, busy_a, busy_b;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      int owner;
      int held;
      int gap;
      int ptr;
      int last;
   } mdl_t;

   mdl_t ma, mb;

   always #5 clk = ~clk;

   mux4_bus_arbiter #(.TURNAROUND(1), .MAX_HOLD(4)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .req(req_a),
      .gnt(gnt_a), .sel(sel_a), .bus_en(bus_en_a), .busy(busy_a)
   );

   mux4_bus_arbiter #(.TURNAROUND(3), .MAX_HOLD(0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .req(req_b),
      .gnt(gnt_b), .sel(sel_b), .bus_en(bus_en_b), .busy(busy_b)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic mdl_t model_reset();
      mdl_t m;
      m.owner = -1; m.held = 0; m.gap = 0; m.ptr = 3; m.last = 0;
      return m;
   endfunction

   function automatic int pick(input logic [3:0] r, input int ptr);
      for (int k = 1; k <= 4; k++)
         if (r[(ptr + k) % 4]) return (ptr + k) % 4;
      return -1;
   endfunction

   // One rising edge of the reference: owner, cycles held, remaining idle gap.
   function automatic mdl_t model_step(input mdl_t mi, input logic [3:0] r, input int tat, input int mh);
      mdl_t m = mi;
      int   w;
      bit   try_grant = 0;
      if (m.owner >= 0) begin
         if (!r[m.owner] || (mh != 0 && m.held == mh)) begin
            m.owner = -1;
            m.gap   = tat;
         end else begin
            m.held = (m.held < 255) ? m.held + 1 : 255;
         end
      end else if (m.gap > 1) begin
         m.gap = m.gap - 1;
      end else begin
         m.gap = 0;
         try_grant = 1;
      end
      if (try_grant) begin
         w = pick(r, m.ptr);
         if (w >= 0) begin
            m.owner = w; m.held = 1; m.ptr = w; m.last = w;
         end
      end
      return m;
   endfunction

   task automatic check_outs(input string tag, input logic [3:0] g, input logic [1:0] s,
                             input logic be, input logic bz, input mdl_t m);
      logic [3:0] eg;
      eg = (m.owner >= 0) ? (4'b0001 << m.owner) : 4'b0000;
      check_eq({tag, "_gnt"}, 32'(g), 32'(eg));
      check_eq({tag, "_sel"}, 32'(s), 32'(m.last));
      check_eq({tag, "_bus_en"}, 32'(be), 32'(m.owner >= 0));
      check_eq({tag, "_busy"}, 32'(bz), 32'(m.owner >= 0 || m.gap > 0));
      check_eq({tag, "_onehot0"}, 32'($onehot0(g)), 32'd1);
      check_eq({tag, "_en_vs_gnt"}, 32'(be), 32'(|g));
   endtask

   task automatic tick();
      ma = model_step(ma, req_a, 1, 4);
      mb = model_step(mb, req_b, 3, 0);
      @(posedge clk);
      #1;
      check_outs("a", gnt_a, sel_a, bus_en_a, busy_a, ma);
      check_outs("b", gnt_b, sel_b, bus_en_b, busy_b, mb);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      ma = model_reset();
      mb = model_reset();
      check_outs("rst_a", gnt_a, sel_a, bus_en_a, busy_a, ma);
      check_outs("rst_b", gnt_b, sel_b, bus_en_b, busy_b, mb);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      ma = model_reset();
      mb = model_reset();
      #1;
      do_reset();

      // Single request, release, one turnaround cycle, back to idle.
      req_a = 4'b0001;
      tick();
      check_eq("t1_gnt", 32'(gnt_a), 32'h1);
      req_a = 4'b0000;
      tick();
      check_eq("t1_turn_busy", 32'(busy_a), 32'd1);
      tick();
      check_eq("t1_idle_busy", 32'(busy_a), 32'd0);

      // All requesting with a hold limit of 4: strict rotation, 4 on / 1 idle.
      do_reset();
      req_a = 4'b1111;
      for (int k = 0; k < 25; k++) begin
         tick();
         check_eq("t2_gnt", 32'(gnt_a), (k % 5 < 4) ? (32'd1 << ((k / 5) % 4)) : 32'd0);
         check_eq("t2_sel", 32'(sel_a), 32'((k / 5) % 4));
      end
      req_a = 4'b0000;

      // Owner 2 releases on the edge requester 1 arrives; three idle cycles first.
      req_b = 4'b0100;
      tick();
      check_eq("t3_own2", 32'(gnt_b), 32'h4);
      tick();
      req_b = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq("t3_gap_en", 32'(bus_en_b), 32'd0);
         check_eq("t3_gap_sel", 32'(sel_b), 32'd2);
      end
      tick();
      check_eq("t3_gnt1", 32'(gnt_b), 32'h2);
      check_eq("t3_sel1", 32'(sel_b), 32'd1);

      // Asynchronous reset in the middle of an ownership.
      req_b = 4'b0000;
      req_a = 4'b0100;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("t4_async_gnt", 32'(gnt_a), 32'h0);
      check_eq("t4_async_en", 32'(bus_en_a), 32'd0);
      check_eq("t4_async_busy", 32'(busy_a), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      ma = model_reset();
      mb = model_reset();
      req_a = 4'b1000;
      tick();
      check_eq("t4_gnt3", 32'(gnt_a), 32'h8);
      req_a = 4'b0000;

      // Unlimited hold: req2 keeps the bus for 300 cycles while req0 toggles.
      for (int i = 0; i < 300; i++) begin
         req_b = 4'b0100 | {3'b000, i[0]};
         tick();
         check_eq("t5_hold", 32'(gnt_b), 32'h4);
      end
      req_b = 4'b0000;
      for (int i = 0; i < 6; i++) tick();

      // Random request traffic on both instances.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 3) == 0) req_a = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) req_b = 4'($urandom_range(0, 15));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
